// File: rtl/karatsuba_alu.sv
// Three-stage pipelined ALU: ADD, SUB, and a Karatsuba-split MULT, with a
// user tag carried alongside each result and valid/ready flow control.
module karatsuba_alu #(
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 2*DIN_W,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  a_operand_i,
  input  logic [DIN_W-1:0]  b_operand_i,
  input  logic [1:0]        opcode_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  output logic [DOUT_W-1:0] data_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              err_o,
  output logic              data_valid_o,
  input  logic              data_ready_i
);

  localparam int HALF_W = DIN_W/2;
  localparam int SUM_W  = HALF_W + 1;
  localparam int Z1_W   = 2*HALF_W + 2;
  localparam int EXT_W  = DOUT_W - DIN_W;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MULT = 2'd2;
  localparam logic [1:0] OP_ILL  = 2'd3;

  // Recombine the three partial products; middle term is never negative.
  function automatic logic [DOUT_W-1:0] kara_combine(
    input logic [DIN_W-1:0] z0,
    input logic [DIN_W-1:0] z2,
    input logic [Z1_W-1:0]  z1
  );
    logic [DOUT_W-1:0] z0_x, z2_x, z1_x, mid;
    z0_x = {{EXT_W{1'b0}}, z0};
    z2_x = {{EXT_W{1'b0}}, z2};
    z1_x = {{(DOUT_W-Z1_W){1'b0}}, z1};
    mid  = z1_x - z0_x - z2_x;
    return (z2_x << DIN_W) + (mid << HALF_W) + z0_x;
  endfunction

  logic stall;

  logic              vld_p1, vld_p2, vld_p3;
  logic [TAG_W-1:0]  tag_p1, tag_p2, tag_p3;
  logic [1:0]        op_p1, op_p2;
  logic [DIN_W-1:0]  z0_p1, z2_p1, z0_p2, z2_p2;
  logic [SUM_W-1:0]  asum_p1, bsum_p1;
  logic [Z1_W-1:0]   z1_p2;
  logic [DOUT_W-1:0] res_p1, res_p2, data_p3;
  logic              err_p3;

  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [DIN_W-1:0]  z0_c, z2_c;
  logic [SUM_W-1:0]  asum_c, bsum_c;
  logic [DOUT_W-1:0] a_x, b_x, res_c;

  assign stall      = vld_p3 & ~data_ready_i;
  assign op_ready_o = ~stall;

  assign a_lo = a_operand_i[HALF_W-1:0];
  assign a_hi = a_operand_i[DIN_W-1:HALF_W];
  assign b_lo = b_operand_i[HALF_W-1:0];
  assign b_hi = b_operand_i[DIN_W-1:HALF_W];

  assign z0_c   = {{HALF_W{1'b0}}, a_lo} * {{HALF_W{1'b0}}, b_lo};
  assign z2_c   = {{HALF_W{1'b0}}, a_hi} * {{HALF_W{1'b0}}, b_hi};
  assign asum_c = {1'b0, a_lo} + {1'b0, a_hi};
  assign bsum_c = {1'b0, b_lo} + {1'b0, b_hi};
  assign a_x    = {{EXT_W{1'b0}}, a_operand_i};
  assign b_x    = {{EXT_W{1'b0}}, b_operand_i};

  always_comb begin
    res_c = '0;
    case (opcode_i)
      OP_ADD:  res_c = a_x + b_x;
      OP_SUB:  res_c = a_x - b_x;
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= op_valid_i;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // S1 -> S2 boundary
  always_ff @(posedge clk) begin
    if (!stall) begin
      tag_p1  <= tag_i;
      op_p1   <= opcode_i;
      z0_p1   <= z0_c;
      z2_p1   <= z2_c;
      asum_p1 <= asum_c;
      bsum_p1 <= bsum_c;
      res_p1  <= res_c;
      tag_p2  <= tag_p1;
      op_p2   <= op_p1;
      z0_p2   <= z0_p1;
      z2_p2   <= z2_p1;
      z1_p2   <= {{(Z1_W-SUM_W){1'b0}}, asum_p1} * {{(Z1_W-SUM_W){1'b0}}, bsum_p1};
      res_p2  <= res_p1;
    end
  end

  // S3: output registers, cleared on reset so outputs read zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p3 <= '0;
      tag_p3  <= '0;
      err_p3  <= 1'b0;
    end else if (!stall) begin
      data_p3 <= (op_p2 == OP_MULT) ? kara_combine(z0_p2, z2_p2, z1_p2) : res_p2;
      tag_p3  <= tag_p2;
      err_p3  <= (op_p2 == OP_ILL);
    end
  end

  assign data_o       = data_p3;
  assign tag_o        = tag_p3;
  assign err_o        = err_p3;
  assign data_valid_o = vld_p3;

endmodule
